saida_buffer: RTL

Output-side counterpart of the switch input buffer: the CPU pushes 16-bit results on `displayWrite`, the block queues them in a small FIFO and paces them to the three seven-segment digits. Each value is converted serially (double-dabble) to BCD and held on the display for a minimum time, or until the user presses enter. The CPU can therefore emit several results back-to-back without the earlier ones being overwritten before they are seen.

---
 rtl/cpmath_io_pkg.sv | 46 ++++
 rtl/bcd_serial.sv | 80 ++++++++
 rtl/saida_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cpmath_io_pkg.sv
// Shared definitions for the CPU display output path.
//   - FSM state encodings for the display pacing controller
//   - Active-low seven-segment codes (bit6=g ... bit0=a) and the blank code
//   - Width of the five-digit BCD result
//   - seg_encode(): one BCD digit to its segment pattern
package cpmath_io_pkg;

  localparam int BCD_W = 20;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CONVERT = 2'd1;
  localparam state_t ST_SHOW    = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Non-decimal nibbles cannot come out of the converter; they map to blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_serial.sv
// Serial double-dabble converter: 16-bit binary to five BCD digits.
//   clk, n_reset : clock, asynchronous active-low reset
//   start        : load value and begin (takes priority over a running job)
//   value        : binary operand sampled on start
//   done         : high during the cycle whose closing edge performs the
//                  16th shift; bcd carries the final result in that cycle
//   bcd          : next-state BCD register, so the caller can capture the
//                  finished digits on the same edge as the last shift
module bcd_serial
  import cpmath_io_pkg::*;
(
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [15:0]      value,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [15:0]      bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj_s;
  logic [3:0]       step_q, step_d;
  logic             active_q, active_d;

  // Add-3 correction applied to every nibble >= 5 before the shift.
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Load on start, otherwise perform one shift step per cycle while active.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    step_d   = step_q;
    active_d = active_q;
    if (start) begin
      bin_d    = value;
      bcd_d    = {BCD_W{1'b0}};
      step_d   = 4'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      bcd_d  = {adj_s[BCD_W-2:0], bin_q[15]};
      bin_d  = {bin_q[14:0], 1'b0};
      step_d = step_q + 4'd1;
      if (step_q == 4'd15) begin
        active_d = 1'b0;
      end else begin
        active_d = 1'b1;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bin_q    <= 16'h0000;
      bcd_q    <= {BCD_W{1'b0}};
      step_q   <= 4'd0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (step_q == 4'd15);
  assign bcd  = bcd_d;

endmodule

// File: rtl/saida_buffer.sv
// CPU result display buffer: queues 16-bit values in a small FIFO, converts
// each to BCD serially and holds it on three seven-segment digits for at
// least HOLD_CYCLES clocks (or until enter is pressed).
//   clk, n_reset                  : clock, asynchronous active-low reset
//   data_in, displayWrite         : push port from the CPU
//   next                          : single-cycle enter pulse, ends a hold
//   display0/1/2                  : units/tens/hundreds, active-low segments
//   ovf                           : shown value exceeds 999
//   full, empty, dropped, busy    : FIFO and controller status
module saida_buffer
  import cpmath_io_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] data_in,
  input  logic        displayWrite,
  input  logic        next,
  output logic [6:0]  display0,
  output logic [6:0]  display1,
  output logic [6:0]  display2,
  output logic        ovf,
  output logic        full,
  output logic        empty,
  output logic        dropped,
  output logic        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             dropped_q, dropped_d;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [6:0]       seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d;
  logic             ovf_q, ovf_d, busy_q, busy_d;

  logic             pop_s, push_ok_s, expired_s, conv_done_s;
  logic [BCD_W-1:0] conv_bcd_s;

  bcd_serial u_bcd (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (pop_s),
    .value   (mem_q[rd_ptr_q]),
    .done    (conv_done_s),
    .bcd     (conv_bcd_s)
  );

  assign expired_s = (timer_q == HOLD_LAST);

  // Display controller: decides when to pop and latches finished digits.
  always_comb begin
    pop_s   = 1'b0;
    state_d = state_q;
    timer_d = timer_q;
    seg0_d  = seg0_q;
    seg1_d  = seg1_q;
    seg2_d  = seg2_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          pop_s   = 1'b1;
          state_d = ST_CONVERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        // Old digits remain visible until the new ones are complete.
        if (conv_done_s) begin
          seg0_d  = seg_encode(conv_bcd_s[3:0]);
          seg1_d  = seg_encode(conv_bcd_s[7:4]);
          seg2_d  = seg_encode(conv_bcd_s[11:8]);
          ovf_d   = |conv_bcd_s[19:12];
          timer_d = {TMR_W{1'b0}};
          state_d = ST_SHOW;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_SHOW: begin
        if (!expired_s) begin
          timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = timer_q;
        end
        // With an empty queue, next has no lasting effect; only the
        // saturated timer remembers that the hold has elapsed.
        if (!empty_q && (expired_s || next)) begin
          pop_s   = 1'b1;
          state_d = ST_CONVERT;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = {TMR_W{1'b0}};
        seg0_d  = SEG_BLANK;
        seg1_d  = SEG_BLANK;
        seg2_d  = SEG_BLANK;
        ovf_d   = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_CONVERT);
  end

  // FIFO bookkeeping; a pop in the same cycle frees room for a push at full.
  always_comb begin
    push_ok_s = displayWrite && (!full_q || pop_s);
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = data_in;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d    = (count_d == CNT_FULL);
    empty_d   = (count_d == {CNT_W{1'b0}});
    dropped_d = dropped_q | (displayWrite & full_q & ~pop_s);
  end

  // All state registers; reset discards queued data and blanks the display.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      dropped_q <= 1'b0;
      state_q   <= ST_IDLE;
      timer_q   <= {TMR_W{1'b0}};
      seg0_q    <= SEG_BLANK;
      seg1_q    <= SEG_BLANK;
      seg2_q    <= SEG_BLANK;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      dropped_q <= dropped_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      seg0_q    <= seg0_d;
      seg1_q    <= seg1_d;
      seg2_q    <= seg2_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign display0 = seg0_q;
  assign display1 = seg1_q;
  assign display2 = seg2_q;
  assign ovf      = ovf_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign dropped  = dropped_q;
  assign busy     = busy_q;

endmodule
